// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the configurable logic block configuration chain:
// FSM state encoding and the chain-geometry derivation helpers.
package clb_cfg_pkg;

  // Configuration FSM states.
  //   ST_IDLE  : no configuration beats accepted since reset or re-arm
  //   ST_LOAD  : some, but not all, beats received
  //   ST_READY : complete configuration held; further beats pass through
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } cfg_state_e;

  // Number of shift beats needed to move the truth table plus the optional
  // mode bit into the block: ceil((mem_size + frac) / chain_width).
  function automatic int calc_beats(input int mem_size, input int frac,
                                    input int chain_width);
    return (mem_size + frac + chain_width - 1) / chain_width;
  endfunction

  // Shift-register length: a whole number of beats, so the top of the
  // register may carry pad bits that the block never looks at.
  function automatic int calc_sr_bits(input int mem_size, input int frac,
                                      input int chain_width);
    return calc_beats(mem_size, frac, chain_width) * chain_width;
  endfunction

endpackage

// File: rtl/lut_frac_read.sv
// LUT read path: selects the output bit(s) from the truth table.
// mode=0 : one K-input function on out0, out1 held low.
// mode=1 : table split into two (K-1)-input halves sharing the low address
//          bits; out0 reads the lower half, out1 the upper half.
// Both outputs are forced low when enable is low (unconfigured block).
module lut_frac_read #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2 ** ADDR_BITS
) (
  input  logic [MEM_SIZE-1:0]  mem,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 enable,
  output logic                 out0,
  output logic                 out1
);

  // Split-mode read indices: low address bits shared, top bit forced to
  // select the lower (idx_lo) or upper (idx_hi) half of the table.
  logic [ADDR_BITS-1:0] idx_lo;
  logic [ADDR_BITS-1:0] idx_hi;

  genvar gi;
  generate
    if (ADDR_BITS == 1) begin : g_k1
      // A 1-input LUT split in two is just two constant cells.
      assign idx_lo = 1'b0;
      assign idx_hi = 1'b1;
    end else begin : g_kn
      for (gi = 0; gi < ADDR_BITS - 1; gi++) begin : g_bit
        assign idx_lo[gi] = addr[gi];
        assign idx_hi[gi] = addr[gi];
      end
      assign idx_lo[ADDR_BITS-1] = 1'b0;
      assign idx_hi[ADDR_BITS-1] = 1'b1;
    end
  endgenerate

  // Zero-latency output mux, gated by the configured flag.
  always_comb begin
    out0 = 1'b0;
    out1 = 1'b0;
    if (enable) begin
      if (mode) begin
        out0 = mem[idx_lo];
        out1 = mem[idx_hi];
      end else begin
        out0 = mem[addr];
      end
    end
  end

endmodule

// File: rtl/lut_config_chain.sv
// Configuration shift chain for one LUT: receives CHAIN_WIDTH config bits per
// beat, tracks how many beats have arrived, reports a complete configuration
// on cfg_done and serves the LUT (optionally fractured) from the shifted-in
// truth table. The chain tail cfg_out feeds the next block in the chain.
module lut_config_chain
  import clb_cfg_pkg::*;
#(
  parameter int ADDR_BITS   = 4,
  parameter int CHAIN_WIDTH = 1,
  parameter int FRAC        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_en,
  input  logic [CHAIN_WIDTH-1:0] cfg_in,
  output logic [CHAIN_WIDTH-1:0] cfg_out,
  output logic                   cfg_done,
  input  logic [ADDR_BITS-1:0]   addr,
  output logic                   lut_out0,
  output logic                   lut_out1
);

  localparam int MEM_SIZE = 2 ** ADDR_BITS;
  localparam int TOTAL    = MEM_SIZE + FRAC;
  localparam int BEATS    = calc_beats(MEM_SIZE, FRAC, CHAIN_WIDTH);
  localparam int SR_BITS  = calc_sr_bits(MEM_SIZE, FRAC, CHAIN_WIDTH);
  localparam int CNT_W    = $clog2(BEATS + 1);

  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Architectural state.
  logic [SR_BITS-1:0] sr_reg;
  logic [SR_BITS-1:0] sr_next;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  cfg_state_e         state_reg;
  cfg_state_e         state_next;
  logic               done_reg;

  // Shift-register value after one beat: new data enters at the top and the
  // oldest beat drops out of the bottom (and onto cfg_out).
  logic [SR_BITS-1:0] sr_shifted;
  logic [CNT_W-1:0]   count_inc;

  generate
    if (SR_BITS == CHAIN_WIDTH) begin : g_one_beat
      // Single-beat chain: the whole register is replaced every beat.
      assign sr_shifted = cfg_in;
    end else begin : g_multi_beat
      assign sr_shifted = {cfg_in, sr_reg[SR_BITS-1:CHAIN_WIDTH]};
    end
  endgenerate

  assign count_inc = count_reg + ONE_C;

  // Next-state logic: re-arm beats shifting, shifting advances the FSM,
  // and anything else holds (a paused load keeps its partial data).
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sr_next    = sr_reg;
    if (cfg_start) begin
      // Re-arm drops back to unconfigured without touching the data, so the
      // chain contents are preserved until new beats overwrite them.
      state_next = ST_IDLE;
      count_next = '0;
    end else if (cfg_en) begin
      sr_next = sr_shifted;
      case (state_reg)
        ST_IDLE: begin
          count_next = ONE_C;
          state_next = (BEATS == 1) ? ST_READY : ST_LOAD;
        end
        ST_LOAD: begin
          count_next = count_inc;
          if (count_inc >= BEATS_C) begin
            state_next = ST_READY;
          end
        end
        ST_READY: begin
          // Pass-through beats for downstream blocks; the count sticks at
          // full so it can never wrap back to a partial value.
          count_next = BEATS_C;
        end
        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // State registers; cfg_done is registered from the next state so it is
  // high exactly while the FSM sits in ST_READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_reg    <= '0;
      count_reg <= '0;
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      sr_reg    <= sr_next;
      count_reg <= count_next;
      state_reg <= state_next;
      done_reg  <= (state_next == ST_READY);
    end
  end

  assign cfg_out  = sr_reg[CHAIN_WIDTH-1:0];
  assign cfg_done = done_reg;

  // Truth table and mode bit as seen by the read path; any pad bits between
  // TOTAL and SR_BITS only travel along the chain.
  logic [MEM_SIZE-1:0] mem;
  logic                mode;

  assign mem = sr_reg[MEM_SIZE-1:0];

  generate
    if (FRAC == 1 && TOTAL <= SR_BITS) begin : g_frac
      assign mode = sr_reg[MEM_SIZE];
    end else begin : g_no_frac
      assign mode = 1'b0;
    end
  endgenerate

  lut_frac_read #(
    .ADDR_BITS (ADDR_BITS),
    .MEM_SIZE  (MEM_SIZE)
  ) u_read (
    .mem    (mem),
    .mode   (mode),
    .addr   (addr),
    .enable (done_reg),
    .out0   (lut_out0),
    .out1   (lut_out1)
  );

endmodule

// File: tb/tb_lut_config_chain.sv
// Directed bench for lut_config_chain: a table of LUT lookups over loaded
// configurations, plus hand-written sequences for pause, re-arm, reset in
// mid-load and a two-block chain.
module tb_lut_config_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Block A: K=4, CW=1, FRAC=1
  logic       start_a, en_a, in_a, out_a, done_a, lo0_a, lo1_a;
  logic [3:0] addr_a;

  // Block B: K=4, CW=4, FRAC=1 (BEATS=5)
  logic       start_b, en_b, done_b, lo0_b, lo1_b;
  logic [3:0] in_b, out_b, addr_b;

  // Chain C: upstream -> downstream, both K=4, CW=1, FRAC=1
  logic       start_c, en_c, in_c;
  logic       up_out, up_done, up_l0, up_l1;
  logic       dn_out, dn_done, dn_l0, dn_l1;
  logic [3:0] up_addr, dn_addr;

  lut_config_chain #(.ADDR_BITS(4), .CHAIN_WIDTH(1), .FRAC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_a), .cfg_en(en_a),
    .cfg_in(in_a), .cfg_out(out_a), .cfg_done(done_a), .addr(addr_a),
    .lut_out0(lo0_a), .lut_out1(lo1_a));

  lut_config_chain #(.ADDR_BITS(4), .CHAIN_WIDTH(4), .FRAC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_b), .cfg_en(en_b),
    .cfg_in(in_b), .cfg_out(out_b), .cfg_done(done_b), .addr(addr_b),
    .lut_out0(lo0_b), .lut_out1(lo1_b));

  lut_config_chain #(.ADDR_BITS(4), .CHAIN_WIDTH(1), .FRAC(1)) u_up (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_c), .cfg_en(en_c),
    .cfg_in(in_c), .cfg_out(up_out), .cfg_done(up_done), .addr(up_addr),
    .lut_out0(up_l0), .lut_out1(up_l1));

  lut_config_chain #(.ADDR_BITS(4), .CHAIN_WIDTH(1), .FRAC(1)) u_dn (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_c), .cfg_en(en_c),
    .cfg_in(up_out), .cfg_out(dn_out), .cfg_done(dn_done), .addr(dn_addr),
    .lut_out0(dn_l0), .lut_out1(dn_l1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at that edge,
  // outputs are looked at 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift bits w[lo..hi] into block A, one per beat, lowest first.
  task automatic shift_a(input logic [16:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_a = w[i];
      en_a = 1'b1;
      step();
    end
    en_a = 1'b0;
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] addr;
    logic       exp0;
    logic       exp1;
  } vec_t;

  localparam logic [15:0] MEM_A = 16'hA5C3;
  localparam logic [15:0] MEM_B = 16'h3C5A;

  vec_t vecs[13];
  logic cur_mode;
  logic [19:0] word_b;

  initial begin
    // mem 16'hA5C3, bit by bit: 0:1 1:1 2:0 3:0 4:0 5:0 6:1 7:1
    //                           8:1 9:0 10:1 11:0 12:0 13:1 14:0 15:1
    vecs[0]  = '{1'b0, 4'd0,    1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd2,    1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd6,    1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd9,    1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd10,   1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd15,   1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'd4,    1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b1000, 1'b1, 1'b1};  // mem[0], mem[8]
    vecs[8]  = '{1'b1, 4'b0010, 1'b0, 1'b1};  // mem[2], mem[10]
    vecs[9]  = '{1'b1, 4'b1101, 1'b0, 1'b1};  // mem[5], mem[13]
    vecs[10] = '{1'b1, 4'b0111, 1'b1, 1'b1};  // mem[7], mem[15]
    vecs[11] = '{1'b1, 4'b0011, 1'b0, 1'b0};  // mem[3], mem[11]
    vecs[12] = '{1'b1, 4'b1100, 1'b0, 1'b0};  // mem[4], mem[12]

    rst_n = 1'b0;
    start_a = 0; en_a = 0; in_a = 0; addr_a = '0;
    start_b = 0; en_b = 0; in_b = '0; addr_b = '0;
    start_c = 0; en_c = 0; in_c = 0; up_addr = '0; dn_addr = '0;
    step();
    step();

    // Reset state
    check("rst_done_a", done_a, 0);
    check("rst_cfg_out_a", out_a, 0);
    check("rst_lut0_a", lo0_a, 0);
    check("rst_lut1_a", lo1_a, 0);
    check("rst_done_b", done_b, 0);
    check("rst_cfg_out_b", out_b, 0);
    rst_n = 1'b1;
    step();

    // First load, mode 0: done must stay low until the 17th beat
    shift_a({1'b0, MEM_A}, 0, 15);
    check("load16_done", done_a, 0);
    check("load16_lut0_gated", lo0_a, 0);
    shift_a({1'b0, MEM_A}, 16, 16);
    check("load17_done", done_a, 1);
    cur_mode = 1'b0;

    // Table-driven lookups; reload (as pass-through beats) on mode change
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].mode != cur_mode) begin
        shift_a({vecs[i].mode, MEM_A}, 0, 16);
        cur_mode = vecs[i].mode;
        check("reload_done", done_a, 1);
      end
      addr_a = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_lut0", i), lo0_a, vecs[i].exp0);
      check($sformatf("vec%0d_lut1", i), lo1_a, vecs[i].exp1);
    end

    // Re-arm in READY with cfg_en high: no shift, block unconfigured
    shift_a({1'b0, MEM_B}, 0, 16);
    check("w2_cfg_out", out_a, 0);
    start_a = 1'b1; en_a = 1'b1; in_a = 1'b1;
    step();
    start_a = 1'b0; en_a = 1'b0;
    addr_a = 4'd1;
    #1;
    check("rearm_done", done_a, 0);
    check("rearm_noshift", out_a, 0);
    check("rearm_lut0", lo0_a, 0);
    shift_a({1'b0, MEM_B}, 0, 15);
    check("rearm16_done", done_a, 0);
    shift_a({1'b0, MEM_B}, 16, 16);
    check("rearm17_done", done_a, 1);
    check("rearm17_lut0_a1", lo0_a, 1);
    addr_a = 4'd0;
    #1;
    check("rearm17_lut0_a0", lo0_a, 0);

    // Reset after beat 9 of a fresh load, with cfg_en still high
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    shift_a({1'b0, MEM_A}, 0, 8);
    rst_n = 1'b0; en_a = 1'b1; in_a = 1'b1;
    step();
    en_a = 1'b0; rst_n = 1'b1;
    check("midrst_done", done_a, 0);
    check("midrst_cfg_out", out_a, 0);
    check("midrst_lut0", lo0_a, 0);
    check("midrst_lut1", lo1_a, 0);
    shift_a({1'b0, MEM_A}, 0, 15);
    check("midrst16_done", done_a, 0);
    shift_a({1'b0, MEM_A}, 16, 16);
    check("midrst17_done", done_a, 1);
    addr_a = 4'd6;
    #1;
    check("midrst17_lut0", lo0_a, 1);

    // CW=4: beats on even iterations, paused with junk data on odd ones
    word_b = {3'b000, 1'b0, MEM_A};  // nibbles 3,C,5,A,0
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) begin
        en_b = 1'b1;
        in_b = word_b[4*(k/2) +: 4];
      end else begin
        en_b = 1'b0;
        in_b = 4'hF;
      end
      step();
      check($sformatf("cw4_k%0d_done", k), done_b, (k == 8) ? 1 : 0);
      check($sformatf("cw4_k%0d_cfg_out", k), out_b, (k == 8) ? 4'h3 : 4'h0);
    end
    en_b = 1'b0;
    addr_b = 4'd0;  #1; check("cw4_lut0_a0", lo0_b, 1);
    addr_b = 4'd2;  #1; check("cw4_lut0_a2", lo0_b, 0);
    addr_b = 4'd13; #1; check("cw4_lut0_a13", lo0_b, 1);
    check("cw4_lut1", lo1_b, 0);
    in_b = 4'hF;
    step();
    check("cw4_pause_cfg_out", out_b, 4'h3);
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    check("cw4_pass_cfg_out", out_b, 4'hC);
    check("cw4_pass_done", done_b, 1);

    // Two-block chain: first 17 beats end downstream, last 17 upstream
    for (int t = 0; t < 34; t++) begin
      in_c = (t < 17) ? MEM_A[0] : 1'b0;
      if (t < 16) in_c = MEM_A[t];
      else if (t == 16) in_c = 1'b0;             // mode bit of downstream word
      else if (t < 33) in_c = MEM_B[t-17];
      else in_c = 1'b1;                          // mode bit of upstream word
      en_c = 1'b1;
      step();
    end
    en_c = 1'b0;
    check("chain_up_done", up_done, 1);
    check("chain_dn_done", dn_done, 1);
    check("chain_dn_cfg_out", dn_out, 1);
    dn_addr = 4'd0; up_addr = 4'b0001;
    #1;
    check("chain_dn_lut0_a0", dn_l0, 1);
    check("chain_dn_lut1_a0", dn_l1, 0);
    check("chain_up_lut0_a1", up_l0, 1);
    check("chain_up_lut1_a1", up_l1, 0);
    dn_addr = 4'd2; up_addr = 4'b0010;
    #1;
    check("chain_dn_lut0_a2", dn_l0, 0);
    check("chain_up_lut0_a2", up_l0, 0);
    check("chain_up_lut1_a2", up_l1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
